// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Latency: n/a (types, constants only).
// Backpressure: n/a.
package pipe_ctrl_pkg;

  // Controller state encoding
  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_BUBBLE = 2'd1,
    ST_WAIT   = 2'd2
  } state_e;

  // Register 0 is hard-wired to zero, so it never carries a real dependency
  localparam logic [4:0] REG_ZERO = 5'd0;

  // Bubble counter holds up to LOAD_LAT-1 (LOAD_LAT <= 7)
  localparam int BCNT_W = 3;
  // Wait counter saturates at TIMEOUT (TIMEOUT <= 255)
  localparam int WCNT_W = 8;

  // Pipeline register enables, grouped so each control pattern is one constant
  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic if_id_flush;
    logic id_exe_write;
    logic id_exe_flush;
  } ctrl_t;

  // Normal flow: everything advances, nothing squashed
  localparam ctrl_t CTRL_RUN    = '{pc_write: 1'b1, if_id_write: 1'b1, if_id_flush: 1'b0,
                                    id_exe_write: 1'b1, id_exe_flush: 1'b0};
  // Memory wait: whole front end holds its contents
  localparam ctrl_t CTRL_FREEZE = '{pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b0,
                                    id_exe_write: 1'b0, id_exe_flush: 1'b0};
  // Taken branch: both younger instructions are squashed, PC loads target
  localparam ctrl_t CTRL_BRANCH = '{pc_write: 1'b1, if_id_write: 1'b1, if_id_flush: 1'b1,
                                    id_exe_write: 1'b1, id_exe_flush: 1'b1};
  // Load-use bubble: PC and IF/ID hold, ID/EXE takes a NOP
  localparam ctrl_t CTRL_BUBBLE = '{pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b0,
                                    id_exe_write: 1'b1, id_exe_flush: 1'b1};
  // Jump in ID: only the sequentially fetched instruction is squashed
  localparam ctrl_t CTRL_JUMP   = '{pc_write: 1'b1, if_id_write: 1'b1, if_id_flush: 1'b1,
                                    id_exe_write: 1'b1, id_exe_flush: 1'b0};

endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// Load-use dependency check between the load in EXE and the instruction in ID.
// Latency: purely combinational, same cycle.
// Backpressure: none; result is consumed by the controller FSM.
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic       ex_mem_read_i,
  input  logic [4:0] ex_dest_i,
  input  logic [4:0] id_rs_i,
  input  logic [4:0] id_rt_i,
  input  logic       id_use_rs_i,
  input  logic       id_use_rt_i,
  output logic       load_use_o
);

  logic rs_hit;
  logic rt_hit;
  logic dest_live;

  // A load writing r0 produces nothing a later instruction can depend on
  assign dest_live = (ex_dest_i != REG_ZERO);
  assign rs_hit    = id_use_rs_i && (ex_dest_i == id_rs_i);
  assign rt_hit    = id_use_rt_i && (ex_dest_i == id_rt_i);
  assign load_use_o = ex_mem_read_i && dest_live && (rs_hit || rt_hit);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// IF/ID and ID/EXE sequencing: load-use bubbles, branch/jump squashes, memory-wait freezes.
// Latency: enables are combinational from state+inputs, effective the same cycle.
// Backpressure: mem_busy freezes all stages; optional stall counter under HAZ_PERF_CNT_EN.
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned LOAD_LAT = 1,
  parameter int unsigned TIMEOUT  = 255,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_dest,
  input  logic             ex_branch_taken,
  input  logic             id_jump,
  input  logic             mem_busy,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_exe_write,
  output logic             id_exe_flush,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles
);

  // Extra bubbles still owed after the first one, issued while in RUN
  localparam logic [BCNT_W-1:0] LAT_M1    = BCNT_W'(LOAD_LAT - 1);
  localparam logic [WCNT_W-1:0] TIMEOUT_C = WCNT_W'(TIMEOUT);

  state_e              state_q, state_d;
  logic [BCNT_W-1:0]   bcnt_q, bcnt_d;
  logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
  logic                tmo_q, tmo_d;
  logic                load_use;
  logic                bubble_owed;
  ctrl_t               ctrl;

  hazard_detect u_hazard_detect (
    .ex_mem_read_i (ex_mem_read),
    .ex_dest_i     (ex_dest),
    .id_rs_i       (id_rs),
    .id_rt_i       (id_rt),
    .id_use_rs_i   (id_use_rs),
    .id_use_rt_i   (id_use_rt),
    .load_use_o    (load_use)
  );

  // Bubbles are still owed in BUBBLE, or in WAIT when the freeze interrupted a bubble run
  assign bubble_owed = (state_q == ST_BUBBLE) || ((state_q == ST_WAIT) && (bcnt_q != '0));

  // Next-state and enables; priority: mem_busy > branch > bubble/load-use > jump > normal
  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    wcnt_d  = '0;
    tmo_d   = tmo_q;
    ctrl    = CTRL_RUN;

    if (mem_busy) begin
      ctrl    = CTRL_FREEZE;
      state_d = ST_WAIT;
      if (state_q == ST_WAIT) begin
        wcnt_d = (wcnt_q >= TIMEOUT_C) ? TIMEOUT_C : (wcnt_q + WCNT_W'(1));
      end else begin
        wcnt_d = WCNT_W'(1);
      end
    end else if (ex_branch_taken) begin
      // Squash also drops any pending or owed load-use bubbles
      ctrl    = CTRL_BRANCH;
      state_d = ST_RUN;
      bcnt_d  = '0;
    end else if (bubble_owed) begin
      ctrl    = CTRL_BUBBLE;
      bcnt_d  = bcnt_q - BCNT_W'(1);
      state_d = (bcnt_q == BCNT_W'(1)) ? ST_RUN : ST_BUBBLE;
    end else if (load_use) begin
      // This cycle is the first bubble; any further ones are counted in BUBBLE
      ctrl    = CTRL_BUBBLE;
      bcnt_d  = LAT_M1;
      state_d = (LAT_M1 != '0) ? ST_BUBBLE : ST_RUN;
    end else if (id_jump) begin
      ctrl    = CTRL_JUMP;
      state_d = ST_RUN;
    end else begin
      state_d = ST_RUN;
    end

    if (wcnt_d == TIMEOUT_C) begin
      tmo_d = 1'b1;
    end

    // Held in reset the pipe sees the plain run pattern
    if (!rst_n) begin
      ctrl = CTRL_RUN;
    end
  end

  // State, counters and sticky timeout flag
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      bcnt_q  <= '0;
      wcnt_q  <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
      wcnt_q  <= wcnt_d;
      tmo_q   <= tmo_d;
    end
  end

  assign pc_write     = ctrl.pc_write;
  assign if_id_write  = ctrl.if_id_write;
  assign if_id_flush  = ctrl.if_id_flush;
  assign id_exe_write = ctrl.id_exe_write;
  assign id_exe_flush = ctrl.id_exe_flush;
  assign mem_timeout  = tmo_q;

`ifdef HAZ_PERF_CNT_EN
  logic [CNT_W-1:0] stall_q, stall_d;

  // Count every cycle the PC is held, wrapping naturally
  always_comb begin
    stall_d = stall_q;
    if (!ctrl.pc_write) begin
      stall_d = stall_q + CNT_W'(1);
    end
  end

  // Stall counter register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cycles = stall_q;
`else
  assign stall_cycles = '0;
`endif

endmodule
